// File: rtl/meta_dispatcher_if.sv
// -----------------------------------------------------------------------------
// meta_dispatcher_pkg / meta_if
//
// Shared metadata type and the valid/ready stream interface used by
// meta_dispatcher for its input and its two output channels.
//
// Handshake: a beat transfers on a rising clk edge when valid && ready are both
// 1. A master holding valid high keeps data stable until the transfer happens.
// Ready may depend on valid and on data.
//
// meta_if signals:
//   data  : metadata_t beat
//   valid : master has a beat
//   ready : slave can take the beat
// Modports: master (drives data/valid), slave (drives ready).
// -----------------------------------------------------------------------------
package meta_dispatcher_pkg;

    typedef struct packed {
        logic [15:0] pkt_size;
        logic [31:0] pkt_addr;
        logic [15:0] pkt_queue_id;
        logic [2:0]  pkt_flags;
    } metadata_t;

    localparam logic [2:0] PKT_PCIE = 3'd1;
    localparam logic [2:0] PKT_DROP = 3'd2;

endpackage

interface meta_if;
    import meta_dispatcher_pkg::*;

    metadata_t data;
    logic      valid;
    logic      ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/meta_dispatcher.sv
// -----------------------------------------------------------------------------
// meta_dispatcher
//
// Routes each accepted metadata beat to the PCIe channel or the drop channel.
// PCIe-flagged beats whose queue id is >= NB_QUEUES, and beats with an unknown
// flag, go to the drop channel with pkt_flags rewritten to PKT_DROP. Each
// output channel is a single register stage; backpressure on one channel only
// stalls beats decoded for that channel.
//
// Optional feature macro: META_DISPATCH_STATS_EN
//   defined   : four 32-bit saturating outcome counters with synchronous clear
//   undefined : counters absent, stats_*_cnt outputs tied to 0, stats_clr unused
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   in_meta (slave)    : input metadata stream from the flow director
//   pcie_meta (master) : metadata bound for the PCIe DMA path
//   drop_meta (master) : metadata whose payload the packet buffer discards
//   stats_clr          : single-cycle clear pulse for all counters
//   stats_pcie_cnt     : beats forwarded to PCIe
//   stats_drop_cnt     : beats arriving flagged PKT_DROP
//   stats_oob_cnt      : PCIe beats demoted because the queue id is out of range
//   stats_bad_flag_cnt : beats with a flag that is neither PKT_PCIE nor PKT_DROP
// -----------------------------------------------------------------------------
module meta_dispatcher
    import meta_dispatcher_pkg::*;
#(
    parameter int NB_QUEUES = 8192
) (
    input  logic        clk,
    input  logic        rst,
    meta_if.slave       in_meta,
    meta_if.master      pcie_meta,
    meta_if.master      drop_meta,
    input  logic        stats_clr,
    output logic [31:0] stats_pcie_cnt,
    output logic [31:0] stats_drop_cnt,
    output logic [31:0] stats_oob_cnt,
    output logic [31:0] stats_bad_flag_cnt
);

    localparam logic [31:0] NB_Q = 32'(NB_QUEUES);

    logic      flag_pcie;
    logic      flag_drop;
    logic      in_range;
    logic      dest_pcie;
    logic      accept;
    logic      load_pcie;
    logic      load_drop;
    logic      pcie_valid_q;
    logic      drop_valid_q;
    metadata_t pcie_data_q;
    metadata_t drop_data_q;
    metadata_t drop_rewrite;

    // Destination decode of the beat currently offered.
    assign flag_pcie = (in_meta.data.pkt_flags == PKT_PCIE);
    assign flag_drop = (in_meta.data.pkt_flags == PKT_DROP);
    assign in_range  = ({16'd0, in_meta.data.pkt_queue_id} < NB_Q);
    assign dest_pcie = flag_pcie && in_range;

    // Ready depends only on the register the current beat is headed for, so a
    // stalled channel never blocks traffic for the other one.
    assign in_meta.ready = dest_pcie ? (!pcie_valid_q || pcie_meta.ready)
                                     : (!drop_valid_q || drop_meta.ready);

    assign accept    = in_meta.valid && in_meta.ready;
    assign load_pcie = accept && dest_pcie;
    assign load_drop = accept && !dest_pcie;

    // Everything reaching the drop channel leaves flagged PKT_DROP; for beats
    // already flagged PKT_DROP this is a no-op.
    always_comb begin
        drop_rewrite           = in_meta.data;
        drop_rewrite.pkt_flags = PKT_DROP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcie_valid_q <= 1'b0;
            drop_valid_q <= 1'b0;
        end else begin
            // A load wins over a drain in the same cycle.
            if (load_pcie)
                pcie_valid_q <= 1'b1;
            else if (pcie_meta.ready)
                pcie_valid_q <= 1'b0;

            if (load_drop)
                drop_valid_q <= 1'b1;
            else if (drop_meta.ready)
                drop_valid_q <= 1'b0;
        end
    end

    // Data registers need no reset; valid qualifies them.
    always_ff @(posedge clk) begin
        if (load_pcie)
            pcie_data_q <= in_meta.data;
        if (load_drop)
            drop_data_q <= drop_rewrite;
    end

    assign pcie_meta.valid = pcie_valid_q;
    assign pcie_meta.data  = pcie_data_q;
    assign drop_meta.valid = drop_valid_q;
    assign drop_meta.data  = drop_data_q;

`ifdef META_DISPATCH_STATS_EN
    logic [31:0] pcie_cnt;
    logic [31:0] drop_cnt;
    logic [31:0] oob_cnt;
    logic [31:0] bad_cnt;
    logic        inc_pcie;
    logic        inc_drop;
    logic        inc_oob;
    logic        inc_bad;

    assign inc_pcie = load_pcie;
    assign inc_drop = accept && flag_drop;
    assign inc_oob  = accept && flag_pcie && !in_range;
    assign inc_bad  = accept && !flag_pcie && !flag_drop;

    // Clear together with an increment leaves the counter at 1; otherwise
    // the counter saturates at all-ones.
    function automatic logic [31:0] cnt_next(input logic [31:0] c,
                                             input logic        inc,
                                             input logic        clr);
        logic [31:0] n;
        if (clr)
            n = {31'd0, inc};
        else if (inc && (c != 32'hFFFF_FFFF))
            n = c + 32'd1;
        else
            n = c;
        return n;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcie_cnt <= 32'd0;
            drop_cnt <= 32'd0;
            oob_cnt  <= 32'd0;
            bad_cnt  <= 32'd0;
        end else begin
            pcie_cnt <= cnt_next(pcie_cnt, inc_pcie, stats_clr);
            drop_cnt <= cnt_next(drop_cnt, inc_drop, stats_clr);
            oob_cnt  <= cnt_next(oob_cnt,  inc_oob,  stats_clr);
            bad_cnt  <= cnt_next(bad_cnt,  inc_bad,  stats_clr);
        end
    end

    assign stats_pcie_cnt     = pcie_cnt;
    assign stats_drop_cnt     = drop_cnt;
    assign stats_oob_cnt      = oob_cnt;
    assign stats_bad_flag_cnt = bad_cnt;
`else
    logic unused_stats_clr;
    assign unused_stats_clr   = stats_clr;

    assign stats_pcie_cnt     = 32'd0;
    assign stats_drop_cnt     = 32'd0;
    assign stats_oob_cnt      = 32'd0;
    assign stats_bad_flag_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_meta_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_meta_dispatcher
//
// Directed bench for meta_dispatcher. Inputs change 1 time unit after a rising
// edge; outputs are sampled there too, reflecting the previous edge.
// Counter expectations follow META_DISPATCH_STATS_EN (0 when it is undefined).
// -----------------------------------------------------------------------------
module tb_meta_dispatcher;
    import meta_dispatcher_pkg::*;

`ifdef META_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stats_clr;
    logic [31:0] stats_pcie_cnt;
    logic [31:0] stats_drop_cnt;
    logic [31:0] stats_oob_cnt;
    logic [31:0] stats_bad_flag_cnt;

    int checks;
    int errors;

    meta_if in_meta ();
    meta_if pcie_meta ();
    meta_if drop_meta ();

    meta_dispatcher #(.NB_QUEUES(8192)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_meta            (in_meta),
        .pcie_meta          (pcie_meta),
        .drop_meta          (drop_meta),
        .stats_clr          (stats_clr),
        .stats_pcie_cnt     (stats_pcie_cnt),
        .stats_drop_cnt     (stats_drop_cnt),
        .stats_oob_cnt      (stats_oob_cnt),
        .stats_bad_flag_cnt (stats_bad_flag_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic metadata_t mk(input logic [2:0] flags, input logic [15:0] q,
                                     input logic [31:0] addr, input logic [15:0] size);
        metadata_t m;
        m.pkt_flags    = flags;
        m.pkt_queue_id = q;
        m.pkt_addr     = addr;
        m.pkt_size     = size;
        return m;
    endfunction

    function automatic metadata_t as_drop(input metadata_t m);
        metadata_t r;
        r           = m;
        r.pkt_flags = PKT_DROP;
        return r;
    endfunction

    function automatic logic [31:0] sc(input logic [31:0] v);
        return STATS ? v : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_meta(input string tag, input metadata_t obs, input metadata_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input metadata_t m);
        in_meta.data  = m;
        in_meta.valid = 1'b1;
        #1;
    endtask

    task automatic idle();
        in_meta.valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    metadata_t m1, m2, m3, m_oob, m_bad, m_edge, m_b2b;

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        stats_clr       = 1'b0;
        in_meta.valid   = 1'b0;
        in_meta.data    = '0;
        pcie_meta.ready = 1'b0;
        drop_meta.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_pcie_valid", {31'd0, pcie_meta.valid}, 32'd0);
        chk("rst_drop_valid", {31'd0, drop_meta.valid}, 32'd0);
        chk("rst_in_ready",   {31'd0, in_meta.ready},   32'd1);
        chk("rst_pcie_cnt",   stats_pcie_cnt,     32'd0);
        chk("rst_drop_cnt",   stats_drop_cnt,     32'd0);
        chk("rst_oob_cnt",    stats_oob_cnt,      32'd0);
        chk("rst_bad_cnt",    stats_bad_flag_cnt, 32'd0);

        // PCIe queue 5, one-cycle latency
        m1 = mk(PKT_PCIE, 16'd5, 32'h0000_1000, 16'd64);
        offer(m1);
        chk("s1_in_ready", {31'd0, in_meta.ready}, 32'd1);
        tick();
        idle();
        chk("s1_pcie_valid", {31'd0, pcie_meta.valid}, 32'd1);
        chk_meta("s1_pcie_data", pcie_meta.data, m1);
        chk("s1_drop_valid", {31'd0, drop_meta.valid}, 32'd0);
        chk("s1_pcie_cnt", stats_pcie_cnt, sc(32'd1));

        // Drop item passes a stalled PCIe channel
        m2 = mk(PKT_DROP, 16'd7, 32'h0000_2000, 16'd128);
        offer(m2);
        chk("s2_in_ready_drop", {31'd0, in_meta.ready}, 32'd1);
        tick();
        idle();
        chk("s2_drop_valid", {31'd0, drop_meta.valid}, 32'd1);
        chk_meta("s2_drop_data", drop_meta.data, m2);
        chk("s2_pcie_valid_held", {31'd0, pcie_meta.valid}, 32'd1);
        chk_meta("s2_pcie_data_held", pcie_meta.data, m1);
        chk("s2_drop_cnt", stats_drop_cnt, sc(32'd1));
        m3 = mk(PKT_PCIE, 16'd9, 32'h0000_3000, 16'd256);
        offer(m3);
        chk("s2_in_ready_pcie_full", {31'd0, in_meta.ready}, 32'd0);
        tick();
        idle();
        chk_meta("s2_pcie_data_unchanged", pcie_meta.data, m1);
        chk("s2_pcie_cnt_unchanged", stats_pcie_cnt, sc(32'd1));

        // Drain both channels
        pcie_meta.ready = 1'b1;
        drop_meta.ready = 1'b1;
        tick();
        chk("drain_pcie_valid", {31'd0, pcie_meta.valid}, 32'd0);
        chk("drain_drop_valid", {31'd0, drop_meta.valid}, 32'd0);

        // Queue id == NB_QUEUES is demoted to drop
        m_oob = mk(PKT_PCIE, 16'd8192, 32'h0000_4000, 16'd32);
        offer(m_oob);
        chk("oob_in_ready", {31'd0, in_meta.ready}, 32'd1);
        tick();
        chk("oob_drop_valid", {31'd0, drop_meta.valid}, 32'd1);
        chk_meta("oob_drop_data", drop_meta.data, as_drop(m_oob));
        chk("oob_pcie_valid", {31'd0, pcie_meta.valid}, 32'd0);
        chk("oob_cnt", stats_oob_cnt, sc(32'd1));

        // Unknown flag is demoted to drop (back-to-back on drop channel)
        m_bad = mk(3'd5, 16'd3, 32'h0000_5000, 16'd16);
        offer(m_bad);
        tick();
        chk("bad_drop_valid", {31'd0, drop_meta.valid}, 32'd1);
        chk_meta("bad_drop_data", drop_meta.data, as_drop(m_bad));
        chk("bad_cnt", stats_bad_flag_cnt, sc(32'd1));
        chk("bad_drop_cnt_same", stats_drop_cnt, sc(32'd1));

        // Highest valid queue id stays on PCIe
        m_edge = mk(PKT_PCIE, 16'd8191, 32'h0000_6000, 16'd8);
        offer(m_edge);
        tick();
        idle();
        chk("edge_pcie_valid", {31'd0, pcie_meta.valid}, 32'd1);
        chk_meta("edge_pcie_data", pcie_meta.data, m_edge);
        chk("edge_drop_valid_drained", {31'd0, drop_meta.valid}, 32'd0);
        chk("edge_pcie_cnt", stats_pcie_cnt, sc(32'd2));
        tick();
        chk("edge_pcie_drained", {31'd0, pcie_meta.valid}, 32'd0);

        // Clear without increment
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("clr_pcie_cnt", stats_pcie_cnt, 32'd0);
        chk("clr_oob_cnt",  stats_oob_cnt,  32'd0);

        // 100 back-to-back PCIe items, no bubbles, in order
        for (int i = 0; i < 100; i++) begin
            m_b2b = mk(PKT_PCIE, 16'(i + 100), 32'(32'hA000_0000 + i), 16'(i));
            offer(m_b2b);
            chk("b2b_in_ready", {31'd0, in_meta.ready}, 32'd1);
            tick();
            chk("b2b_pcie_valid", {31'd0, pcie_meta.valid}, 32'd1);
            chk_meta("b2b_pcie_data", pcie_meta.data, m_b2b);
        end
        idle();
        tick();
        chk("b2b_pcie_drained", {31'd0, pcie_meta.valid}, 32'd0);
        chk("b2b_pcie_cnt", stats_pcie_cnt, sc(32'd100));
        chk("b2b_drop_cnt", stats_drop_cnt, 32'd0);

`ifdef META_DISPATCH_STATS_EN
        // Saturation and clear-with-increment
        dut.pcie_cnt = 32'hFFFF_FFFF;
        offer(mk(PKT_PCIE, 16'd1, 32'h0000_7000, 16'd4));
        tick();
        chk("sat_pcie_cnt", stats_pcie_cnt, 32'hFFFF_FFFF);
        offer(mk(PKT_PCIE, 16'd2, 32'h0000_7004, 16'd4));
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        idle();
        chk("clr_inc_pcie_cnt", stats_pcie_cnt, 32'd1);
        chk("clr_only_drop_cnt", stats_drop_cnt, 32'd0);
`else
        chk("nostats_pcie_cnt", stats_pcie_cnt,     32'd0);
        chk("nostats_drop_cnt", stats_drop_cnt,     32'd0);
        chk("nostats_oob_cnt",  stats_oob_cnt,      32'd0);
        chk("nostats_bad_cnt",  stats_bad_flag_cnt, 32'd0);
`endif

        // Asynchronous reset drops in-flight contents
        pcie_meta.ready = 1'b0;
        offer(mk(PKT_PCIE, 16'd11, 32'h0000_8000, 16'd2));
        tick();
        idle();
        chk("pre_rst_pcie_valid", {31'd0, pcie_meta.valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pcie_valid", {31'd0, pcie_meta.valid}, 32'd0);
        chk("async_rst_pcie_cnt", stats_pcie_cnt, 32'd0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
